// File: rtl/aes_in_seq_if.sv
// Beat-in / block-out bus of aes_in_seq; the slave modport is the sequencer's view.
// AES_IN_SEQ_LASTCHK_EN adds the i_last framing marker and the o_err pulse.
interface aes_in_seq_if #(
  parameter int BEATS = 4,
  parameter int BYTES = 4
);
  logic [BYTES-1:0][7:0]       i_data;
  logic                        i_valid;
  logic                        i_ready;
  logic [BEATS*BYTES-1:0][7:0] o_block;
  logic                        o_valid;
  logic                        o_ready;
  logic [7:0]                  o_blk_cnt;
`ifdef AES_IN_SEQ_LASTCHK_EN
  logic                        i_last;
  logic                        o_err;

  modport slave (
    input  i_data, i_valid, i_last, o_ready,
    output i_ready, o_block, o_valid, o_blk_cnt, o_err
  );
  modport master (
    output i_data, i_valid, i_last, o_ready,
    input  i_ready, o_block, o_valid, o_blk_cnt, o_err
  );
`else
  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_block, o_valid, o_blk_cnt
  );
  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_block, o_valid, o_blk_cnt
  );
`endif
endinterface

// File: rtl/aes_in_seq.sv
// Packs four 4-byte beats into one 16-byte AES block; o_valid one clock after beat 4,
// i_ready drops only while a held block is not taken. AES_IN_SEQ_LASTCHK_EN adds i_last framing checks.
module aes_in_seq #(
  parameter int BEATS = 4,
  parameter int BYTES = 4
) (
  input logic         clk,
  input logic         resetn,
  aes_in_seq_if.slave bus
);
  localparam int KW = $clog2(BEATS);
  localparam int JW = $clog2(BYTES);
  localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [BEATS*BYTES-1:0][7:0] blk_q, blk_d;
  logic                        vld_q, vld_d;
  logic [7:0]                  cnt_q, cnt_d;
`ifdef AES_IN_SEQ_LASTCHK_EN
  logic                        err_q, err_d;
`endif

  logic in_hs;
  logic out_hs;

  assign bus.i_ready   = (state_q != FULL) || bus.o_ready;
  assign in_hs         = bus.i_valid && bus.i_ready;
  assign out_hs        = vld_q && bus.o_ready;
  assign bus.o_block   = blk_q;
  assign bus.o_valid   = vld_q;
  assign bus.o_blk_cnt = cnt_q;
`ifdef AES_IN_SEQ_LASTCHK_EN
  assign bus.o_err     = err_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    blk_d   = blk_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
`ifdef AES_IN_SEQ_LASTCHK_EN
    err_d   = 1'b0;
`endif
    if (out_hs) begin
      cnt_d   = cnt_q + 8'd1;
      vld_d   = 1'b0;
      state_d = IDLE;
    end
    // A beat accepted alongside the drain lands in slot 0 of the next block.
    if (in_hs) begin
      for (int j = 0; j < BYTES; j++) begin
        blk_d[{k_q, JW'(j)}] = bus.i_data[j];
      end
      if (k_q == LAST_BEAT) begin
        k_d     = '0;
        state_d = FULL;
        vld_d   = 1'b1;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = FILL;
      end
`ifdef AES_IN_SEQ_LASTCHK_EN
      if (bus.i_last != (k_q == LAST_BEAT)) begin
        err_d   = 1'b1;
        k_d     = '0;
        state_d = IDLE;
        vld_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      blk_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef AES_IN_SEQ_LASTCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      blk_q   <= blk_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
`ifdef AES_IN_SEQ_LASTCHK_EN
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes_in_seq.sv
// Bench for aes_in_seq: directed block scenarios plus random streaming against a byte-image model.
module tb_aes_in_seq;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  aes_in_seq_if bus ();
  aes_in_seq dut (.clk(clk), .resetn(resetn), .bus(bus));

`ifdef AES_IN_SEQ_LASTCHK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: byte image of the block register, beats held in the open block,
  // whether a complete block waits for the core, delivered count, pending error pulse.
  logic [15:0][7:0] m_img;
  int               m_nb;
  bit               m_full;
  int               m_cnt;
  bit               m_err;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_img  = '0;
    m_nb   = 0;
    m_full = 1'b0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("o_valid", bus.o_valid, m_full);
    chk("o_blk_cnt", bus.o_blk_cnt, m_cnt[7:0]);
    if (m_full || !LC) chk("o_block", bus.o_block, m_img);
`ifdef AES_IN_SEQ_LASTCHK_EN
    chk("o_err", bus.o_err, m_err);
`endif
  endtask

  task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit last);
    bit rdy, in_hs, out_hs;
    @(negedge clk);
    check_outputs();
    bus.i_valid = iv;
    bus.i_data  = d;
    bus.o_ready = ordy;
`ifdef AES_IN_SEQ_LASTCHK_EN
    bus.i_last  = last;
`endif
    #1;
    rdy = !m_full || ordy;
    chk("i_ready", bus.i_ready, rdy);
    in_hs  = iv && rdy;
    out_hs = m_full && ordy;
    m_err  = 1'b0;
    if (out_hs) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_full = 1'b0;
    end
    if (in_hs) begin
      for (int j = 0; j < 4; j++) m_img[4*m_nb + j] = d[8*j +: 8];
      if (LC && (last != (m_nb == 3))) begin
        m_err = 1'b1;
        m_nb  = 0;
      end else if (m_nb == 3) begin
        m_nb   = 0;
        m_full = 1'b1;
      end else begin
        m_nb++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn      = 1'b0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    #1;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_blk_cnt", bus.o_blk_cnt, 8'd0);
    chk("rst_o_block", bus.o_block, 128'd0);
`ifdef AES_IN_SEQ_LASTCHK_EN
    chk("rst_o_err", bus.o_err, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
`ifdef AES_IN_SEQ_LASTCHK_EN
    bus.i_last  = 1'b0;
`endif
    model_reset();
    do_reset();

    // Four back-to-back beats, core not ready.
    cyc(1, 32'h03020100, 0, 0);
    cyc(1, 32'h07060504, 0, 0);
    cyc(1, 32'h0B0A0908, 0, 0);
    cyc(1, 32'h0F0E0D0C, 0, 1);
    cyc(0, 32'h0, 0, 0);
    chk("blk_first", bus.o_block, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("vld_first", bus.o_valid, 1'b1);
    chk("rdy_held", bus.i_ready, 1'b0);

    // Held block must ignore pushed data.
    repeat (10) cyc(1, 32'hFFFFFFFF, 0, 0);
    cyc(0, 32'h0, 0, 0);
    chk("blk_hold", bus.o_block, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Drain and accept in the same cycle.
    cyc(1, 32'hAABBCCDD, 1, 0);
    cyc(0, 32'h0, 0, 0);
    chk("blk_overlap", bus.o_block, 128'h0F0E0D0C_0B0A0908_07060504_AABBCCDD);
    chk("cnt_overlap", bus.o_blk_cnt, 8'd1);
    chk("vld_overlap", bus.o_valid, 1'b0);

    // Full-rate stream long enough to wrap the block counter.
    for (int n = 0; n < 1100; n++) cyc(1, $urandom, 1, m_nb == 3);

    // Random valid/ready pressure, occasional framing faults when checked.
    for (int n = 0; n < 2000; n++) begin
      bit fault;
      fault = LC && ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 9) < 8, $urandom, ($urandom % 4) != 0, (m_nb == 3) ^ fault);
    end

    // Reset mid-fill, then a clean block.
    do_reset();
    cyc(1, 32'hDEADBEEF, 0, 0);
    cyc(1, 32'hCAFEF00D, 0, 0);
    do_reset();
    cyc(1, 32'h13121110, 0, 0);
    cyc(1, 32'h17161514, 0, 0);
    cyc(1, 32'h1B1A1918, 0, 0);
    cyc(1, 32'h1F1E1D1C, 0, 1);
    cyc(0, 32'h0, 0, 0);
    chk("blk_after_rst", bus.o_block, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
    chk("vld_after_rst", bus.o_valid, 1'b1);

`ifdef AES_IN_SEQ_LASTCHK_EN
    cyc(0, 32'h0, 1, 0);
    cyc(1, 32'h23222120, 0, 0);
    cyc(1, 32'h27262524, 0, 1);
    cyc(0, 32'h0, 0, 0);
    chk("err_early_last", bus.o_err, 1'b1);
    chk("vld_early_last", bus.o_valid, 1'b0);
    cyc(0, 32'h0, 0, 0);
    chk("err_pulse_end", bus.o_err, 1'b0);
    cyc(1, 32'h33323130, 0, 0);
    cyc(1, 32'h37363534, 0, 0);
    cyc(1, 32'h3B3A3938, 0, 0);
    cyc(1, 32'h3F3E3D3C, 0, 1);
    cyc(0, 32'h0, 0, 0);
    chk("blk_after_err", bus.o_block, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
    chk("vld_after_err", bus.o_valid, 1'b1);
    chk("err_after_ok", bus.o_err, 1'b0);
`endif

    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
